// File: rtl/ula_pkg.sv
// Shared definitions for the nibble ALU and its multi-precision sequencer:
// operation encodings, sequencer FSM states and an index-width helper.
package ula_pkg;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Width of a nibble index; never narrower than one bit.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/ula_nib_mux.sv
// Selects nibble idx out of a wide word (nibble 0 is the least significant).
module ula_nib_mux #(
    parameter int NIB   = 4,
    parameter int WORDS = 4,
    parameter int IDX_W = 2
) (
    input  logic [NIB*WORDS-1:0] word,
    input  logic [IDX_W-1:0]     idx,
    output logic [NIB-1:0]       nib
);

    always_comb begin
        nib = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib = word[i*NIB +: NIB];
            end
        end
    end

endmodule

// File: rtl/ula_mp_seq.sv
// Runs a WORDS*NIB-bit operation through one external NIB-bit ula, one nibble
// per cycle LSB first, chaining carry and assembling the wide result and flags.
module ula_mp_seq
    import ula_pkg::*;
#(
    parameter int NIB   = 4,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NIB*WORDS-1:0] a,
    input  logic [NIB*WORDS-1:0] b,
    input  logic                 a_inv,
    input  logic                 b_inv,
    input  logic                 c_in,
    input  logic [1:0]           alu_op,
    output logic                 busy,
    output logic                 done,
    output logic [NIB*WORDS-1:0] result,
    output logic                 N,
    output logic                 C,
    output logic                 V,
    output logic                 Z,
    output logic [NIB-1:0]       ula_a,
    output logic [NIB-1:0]       ula_b,
    output logic                 ula_a_inv,
    output logic                 ula_b_inv,
    output logic                 ula_c_in,
    output logic [1:0]           ula_alu_op,
    input  logic [NIB-1:0]       ula_out,
    input  logic                 ula_n,
    input  logic                 ula_c,
    input  logic                 ula_v,
    input  logic                 ula_z
);

    localparam int W     = NIB * WORDS;
    localparam int IDX_W = idx_width(WORDS);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, result_q, result_d;
    logic             a_inv_q, a_inv_d, b_inv_q, b_inv_d;
    logic [1:0]       op_q, op_d;
    logic             carry_q, carry_d, z_acc_q, z_acc_d;
    logic             n_q, n_d, c_q, c_d, v_q, v_d, z_q, z_d;
    logic             done_q, done_d;
    logic             last;
    logic             run;
    logic [NIB-1:0]   a_nib, b_nib;
    logic             ula_n_unused;

    assign ula_n_unused = ula_n;
    assign last = (idx_q == IDX_W'(WORDS - 1));
    assign run  = (state_q == RUN);

    ula_nib_mux #(.NIB(NIB), .WORDS(WORDS), .IDX_W(IDX_W)) u_mux_a (
        .word(a_q), .idx(idx_q), .nib(a_nib)
    );
    ula_nib_mux #(.NIB(NIB), .WORDS(WORDS), .IDX_W(IDX_W)) u_mux_b (
        .word(b_q), .idx(idx_q), .nib(b_nib)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        a_inv_d  = a_inv_q;
        b_inv_d  = b_inv_q;
        op_d     = op_q;
        carry_d  = carry_q;
        z_acc_d  = z_acc_q;
        result_d = result_q;
        n_d      = n_q;
        c_d      = c_q;
        v_d      = v_q;
        z_d      = z_q;
        // The done pulse trails the DONE state by one cycle so the wide
        // result and flags are already settled when it is seen.
        done_d   = (state_q == DONE);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    a_inv_d = a_inv;
                    b_inv_d = b_inv;
                    op_d    = alu_op;
                    carry_d = c_in;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < WORDS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        result_d[i*NIB +: NIB] = ula_out;
                    end
                end
                carry_d = ula_c;
                z_acc_d = (idx_q == '0) ? ula_z : (z_acc_q & ula_z);
                if (last) begin
                    c_d     = ula_c;
                    v_d     = ula_v;
                    z_d     = z_acc_d;
                    n_d     = ula_out[NIB-1];
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            a_inv_q  <= 1'b0;
            b_inv_q  <= 1'b0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            z_acc_q  <= 1'b0;
            result_q <= '0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a_inv_q  <= a_inv_d;
            b_inv_q  <= b_inv_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            z_acc_q  <= z_acc_d;
            result_q <= result_d;
            n_q      <= n_d;
            c_q      <= c_d;
            v_q      <= v_d;
            z_q      <= z_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign N      = n_q;
    assign C      = c_q;
    assign V      = v_q;
    assign Z      = z_q;

    // The ula sees nothing but zeros unless a nibble is actually in flight.
    assign ula_a      = run ? a_nib   : '0;
    assign ula_b      = run ? b_nib   : '0;
    assign ula_a_inv  = run & a_inv_q;
    assign ula_b_inv  = run & b_inv_q;
    assign ula_c_in   = run & carry_q;
    assign ula_alu_op = run ? op_q    : 2'b00;

endmodule
